// File: rtl/alu_result_stage_if.sv
// ---------------------------------------------------------------------------
// alu_result_stage_if
// Bundles the operand/result bus and both valid/ready handshakes of the
// ALU result stage.
//   a, b                 operands that fed basic_alu
//   a_plus_b .. a_xor_b  combinational basic_alu results
//   op                   operation select (0 ADD .. 6 PASS_A, 7 reserved)
//   in_valid / in_ready  upstream handshake
//   out_valid/out_ready  downstream handshake
//   result, carry, zero, neg, err   head entry of the output buffer
//   op_count             accepted operations, mod 256
// Modports: master = upstream producer + downstream consumer side,
//           slave  = the result stage itself.
// ---------------------------------------------------------------------------
interface alu_result_stage_if #(
   parameter int DATA_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic [DATA_WIDTH-1:0] a_plus_b;
   logic [DATA_WIDTH-1:0] a_minus_b;
   logic [DATA_WIDTH-1:0] not_a;
   logic [DATA_WIDTH-1:0] a_and_b;
   logic [DATA_WIDTH-1:0] a_or_b;
   logic [DATA_WIDTH-1:0] a_xor_b;
   logic [2:0]            op;
   logic                  in_valid;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] result;
   logic                  carry;
   logic                  zero;
   logic                  neg;
   logic                  err;
   logic [7:0]            op_count;

   modport master (
      output a, b, a_plus_b, a_minus_b, not_a, a_and_b, a_or_b, a_xor_b,
      output op, in_valid, out_ready,
      input  in_ready, out_valid, result, carry, zero, neg, err, op_count
   );

   modport slave (
      input  a, b, a_plus_b, a_minus_b, not_a, a_and_b, a_or_b, a_xor_b,
      input  op, in_valid, out_ready,
      output in_ready, out_valid, result, carry, zero, neg, err, op_count
   );
endinterface

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
// Registered output stage behind basic_alu. Selects one ALU result by opcode,
// derives carry/borrow, zero, negative and error flags, and buffers the
// selected entry in a 2-deep FIFO with valid/ready handshakes on both sides.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset (deassertion assumed synchronised
//           to clk by the reset tree)
//   bus     alu_result_stage_if.slave -- operands, ALU results, op select,
//           both handshakes, head-entry outputs and op_count
// ---------------------------------------------------------------------------
module alu_result_stage #(
   parameter int DATA_WIDTH = 4
) (
   input logic               clk,
   input logic               resetn,
   alu_result_stage_if.slave bus
);

   localparam int EntryWidth = DATA_WIDTH + 4;

   typedef enum logic [2:0] {
      OP_ADD    = 3'd0,
      OP_SUB    = 3'd1,
      OP_NOT    = 3'd2,
      OP_AND    = 3'd3,
      OP_OR     = 3'd4,
      OP_XOR    = 3'd5,
      OP_PASS_A = 3'd6,
      OP_RSVD   = 3'd7
   } op_e;

   // Entry layout: {err, neg, zero, carry, result}
   logic [EntryWidth-1:0] mem_q [2];
   logic [EntryWidth-1:0] last_q, last_d;
   logic                  rd_q, rd_d;
   logic                  wr_q, wr_d;
   logic [1:0]            count_q, count_d;
   logic [7:0]            op_count_q, op_count_d;

   logic [DATA_WIDTH:0]   sum_wide;
   logic [DATA_WIDTH-1:0] sel_result;
   logic                  sel_carry;
   logic                  sel_err;
   logic                  sel_zero;
   logic                  sel_neg;
   logic [EntryWidth-1:0] new_entry;
   logic [EntryWidth-1:0] head;
   logic                  push;
   logic                  pop;
   op_e                   op_sel;

   // Carry is taken from a widened add so it never relies on the truncated
   // ALU output.
   assign sum_wide = {1'b0, bus.a} + {1'b0, bus.b};
   assign op_sel   = op_e'(bus.op);

   // Result/flag selection. The reserved op yields a zero result, which
   // naturally gives zero=1 and neg=0.
   always_comb begin
      sel_result = '0;
      sel_carry  = 1'b0;
      sel_err    = 1'b0;
      case (op_sel)
         OP_ADD: begin
            sel_result = bus.a_plus_b;
            sel_carry  = sum_wide[DATA_WIDTH];
         end
         OP_SUB: begin
            sel_result = bus.a_minus_b;
            sel_carry  = (bus.a < bus.b);
         end
         OP_NOT:    sel_result = bus.not_a;
         OP_AND:    sel_result = bus.a_and_b;
         OP_OR:     sel_result = bus.a_or_b;
         OP_XOR:    sel_result = bus.a_xor_b;
         OP_PASS_A: sel_result = bus.a;
         OP_RSVD:   sel_err    = 1'b1;
         default:   sel_err    = 1'b1;
      endcase
   end

   assign sel_zero  = (sel_result == '0);
   assign sel_neg   = sel_result[DATA_WIDTH-1];
   assign new_entry = {sel_err, sel_neg, sel_zero, sel_carry, sel_result};

   // in_ready depends only on registered occupancy, so a full buffer refuses
   // a push even when it is popped in the same cycle.
   assign bus.in_ready  = (count_q != 2'd2);
   assign bus.out_valid = (count_q != 2'd0);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   // When empty, the outputs keep showing the most recently popped entry.
   assign head         = bus.out_valid ? mem_q[rd_q] : last_q;
   assign bus.result   = head[DATA_WIDTH-1:0];
   assign bus.carry    = head[DATA_WIDTH];
   assign bus.zero     = head[DATA_WIDTH+1];
   assign bus.neg      = head[DATA_WIDTH+2];
   assign bus.err      = head[DATA_WIDTH+3];
   assign bus.op_count = op_count_q;

   // Next-state for pointers, occupancy, hold register and op counter.
   // One-bit pointers wrap 1->0 by themselves.
   always_comb begin
      rd_d       = rd_q;
      wr_d       = wr_q;
      count_d    = count_q;
      last_d     = last_q;
      op_count_d = op_count_q;
      if (push) begin
         wr_d       = ~wr_q;
         op_count_d = op_count_q + 8'd1;
      end
      if (pop) begin
         rd_d   = ~rd_q;
         last_d = mem_q[rd_q];
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // State registers; entry storage is written at the tail on each push.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         last_q     <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         count_q    <= 2'd0;
         op_count_q <= 8'd0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= new_entry;
         end
         last_q     <= last_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         count_q    <= count_d;
         op_count_q <= op_count_d;
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
// Directed bench for alu_result_stage with a scoreboard queue of expected
// entries and a reference model of the selection/flag logic.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

   logic clk;
   logic resetn;

   int checks;
   int errors;
   int opCountExp;
   int curOp;
   int curA;
   int curB;
   logic [7:0] lastExp;
   logic [7:0] sbQueue [$];

   alu_result_stage_if #(.DATA_WIDTH(4)) bus ();

   alu_result_stage #(.DATA_WIDTH(4)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guard against a hung run
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: entry {err, neg, zero, carry, result[3:0]}
   function automatic logic [7:0] entryModel(int op, int a, int b);
      int         r;
      logic       c;
      logic       e;
      logic [3:0] rv;
      c = 1'b0;
      e = 1'b0;
      case (op)
         0: begin r = (a + b) % 16; c = ((a + b) > 15); end
         1: begin r = (a - b + 16) % 16; c = (a < b); end
         2: r = 15 - a;
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = a;
         default: begin r = 0; e = 1'b1; end
      endcase
      rv = r[3:0];
      return {e, (r >= 8), (r == 0), c, rv};
   endfunction

   task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one operation the way basic_alu would present it
   task automatic applyStimulus(int op, int a, int b, bit valid);
      logic [3:0] av;
      logic [3:0] bv;
      av = a[3:0];
      bv = b[3:0];
      curOp = op;
      curA  = a;
      curB  = b;
      bus.op        = op[2:0];
      bus.a         = av;
      bus.b         = bv;
      bus.a_plus_b  = av + bv;
      bus.a_minus_b = av - bv;
      bus.not_a     = ~av;
      bus.a_and_b   = av & bv;
      bus.a_or_b    = av | bv;
      bus.a_xor_b   = av ^ bv;
      bus.in_valid  = valid;
   endtask

   // One clock: compare at the falling edge against the scoreboard, update
   // the model for the handshakes taking place on the next rising edge.
   task automatic tick();
      logic [7:0] exp;
      bit         mPush;
      bit         mPop;
      @(negedge clk);
      checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, sbQueue.size() != 2});
      checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, sbQueue.size() != 0});
      checkOutput("op_count", {24'd0, bus.op_count}, opCountExp);
      exp = (sbQueue.size() != 0) ? sbQueue[0] : lastExp;
      checkOutput("result", {28'd0, bus.result}, {28'd0, exp[3:0]});
      checkOutput("carry", {31'd0, bus.carry}, {31'd0, exp[4]});
      checkOutput("zero", {31'd0, bus.zero}, {31'd0, exp[5]});
      checkOutput("neg", {31'd0, bus.neg}, {31'd0, exp[6]});
      checkOutput("err", {31'd0, bus.err}, {31'd0, exp[7]});
      mPop  = (sbQueue.size() != 0) && bus.out_ready;
      mPush = bus.in_valid && (sbQueue.size() != 2);
      if (mPop) lastExp = sbQueue.pop_front();
      if (mPush) begin
         sbQueue.push_back(entryModel(curOp, curA, curB));
         opCountExp = (opCountExp + 1) % 256;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      opCountExp = 0;
      lastExp    = 8'd0;
      resetn     = 1'b0;
      bus.out_ready = 1'b1;
      applyStimulus(0, 0, 0, 1'b0);

      // Reset state
      #12;
      checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 0);
      checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 1);
      checkOutput("rst_result", {28'd0, bus.result}, 0);
      checkOutput("rst_op_count", {24'd0, bus.op_count}, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // ADD 12+12 wraps to 8 with carry
      applyStimulus(0, 12, 12, 1'b1);
      tick();
      checkOutput("add_result", {28'd0, bus.result}, 8);
      checkOutput("add_carry", {31'd0, bus.carry}, 1);
      checkOutput("add_neg", {31'd0, bus.neg}, 1);
      checkOutput("add_op_count", {24'd0, bus.op_count}, 1);

      // SUB with and without borrow
      applyStimulus(1, 5, 10, 1'b1);
      tick();
      checkOutput("sub_borrow_result", {28'd0, bus.result}, 11);
      checkOutput("sub_borrow_carry", {31'd0, bus.carry}, 1);
      applyStimulus(1, 9, 8, 1'b1);
      tick();
      checkOutput("sub_result", {28'd0, bus.result}, 1);
      checkOutput("sub_carry", {31'd0, bus.carry}, 0);

      // Zero results and reserved op
      applyStimulus(5, 9, 9, 1'b1);
      tick();
      checkOutput("xor_zero", {31'd0, bus.zero}, 1);
      applyStimulus(2, 15, 3, 1'b1);
      tick();
      checkOutput("not_result", {28'd0, bus.result}, 0);
      applyStimulus(7, 6, 5, 1'b1);
      tick();
      checkOutput("rsvd_err", {31'd0, bus.err}, 1);
      checkOutput("rsvd_result", {28'd0, bus.result}, 0);

      // Idle with junk inputs: buffer drains, outputs hold last popped entry
      applyStimulus(3, 7, 13, 1'b0);
      tick();
      tick();
      checkOutput("hold_valid", {31'd0, bus.out_valid}, 0);
      checkOutput("hold_err", {31'd0, bus.err}, 1);

      // Back-pressure: third op is held while full
      bus.out_ready = 1'b0;
      applyStimulus(0, 15, 1, 1'b1);
      tick();
      applyStimulus(3, 14, 2, 1'b1);
      tick();
      checkOutput("full_in_ready", {31'd0, bus.in_ready}, 0);
      applyStimulus(4, 13, 3, 1'b1);
      tick();
      tick();
      checkOutput("held_in_ready", {31'd0, bus.in_ready}, 0);
      checkOutput("bp_head0", {28'd0, bus.result}, 0);
      checkOutput("bp_head0_carry", {31'd0, bus.carry}, 1);
      bus.out_ready = 1'b1;
      tick();
      checkOutput("bp_head1", {28'd0, bus.result}, 2);
      tick();
      checkOutput("bp_head2", {28'd0, bus.result}, 15);
      applyStimulus(0, 0, 0, 1'b0);
      tick();
      checkOutput("bp_drained", {31'd0, bus.out_valid}, 0);

      // Fill both entries then reset asynchronously between edges
      bus.out_ready = 1'b0;
      applyStimulus(0, 3, 4, 1'b1);
      tick();
      applyStimulus(1, 7, 2, 1'b1);
      tick();
      applyStimulus(0, 0, 0, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("async_out_valid", {31'd0, bus.out_valid}, 0);
      checkOutput("async_result", {28'd0, bus.result}, 0);
      checkOutput("async_flags", {28'd0, bus.carry, bus.zero, bus.neg, bus.err}, 0);
      checkOutput("async_in_ready", {31'd0, bus.in_ready}, 1);
      checkOutput("async_op_count", {24'd0, bus.op_count}, 0);
      sbQueue.delete();
      lastExp    = 8'd0;
      opCountExp = 0;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_rst_valid", {31'd0, bus.out_valid}, 0);

      // Continuous stream of 300 accepts
      bus.out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)), 1'b1);
         tick();
      end
      applyStimulus(0, 0, 0, 1'b0);
      for (int i = 0; i < 4 && sbQueue.size() != 0; i++) tick();
      checkOutput("stream_drain", sbQueue.size(), 0);
      checkOutput("stream_op_count", {24'd0, bus.op_count}, 44);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
